// File: rtl/alu_cmd_driver_if.sv
// Command, ALU-operand and response bundle for alu_cmd_driver.
// rsp_tag exists only when ALU_DRV_TAG_EN is defined.
interface alu_cmd_driver_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [3:0]       cmd_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic [8:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_a;
  logic [7:0]       rsp_b;
  logic [3:0]       rsp_op;
  logic [8:0]       rsp_out;
  logic             busy;
  logic [CNT_W-1:0] issued_cnt;
`ifdef ALU_DRV_TAG_EN
  logic [3:0]       rsp_tag;
`endif

  // master: the driver itself
  modport master (
`ifdef ALU_DRV_TAG_EN
    output rsp_tag,
`endif
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_a, rsp_b, rsp_op, rsp_out, busy, issued_cnt
  );

  // slave: sequencer, ALU and response consumer around the driver
  modport slave (
`ifdef ALU_DRV_TAG_EN
    input  rsp_tag,
`endif
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_a, rsp_b, rsp_op, rsp_out, busy, issued_cnt
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Buffers (a,b,op) commands in a FIFO, issues them one at a time to a combinational ALU
// and returns the sampled result on a valid/ready port. Define ALU_DRV_TAG_EN to add rsp_tag.
module alu_cmd_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_driver_if.master bus
);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W    = PTR_W + 1;
  localparam int unsigned LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int unsigned LAT_LAST = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;

  typedef struct packed {
`ifdef ALU_DRV_TAG_EN
    logic [3:0] tag;
`endif
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_HOLD} state_t;

  state_t           state, state_next;
  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           cur;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_next;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] issued_q;
  logic             push, pop;
  logic             load_alu, capture, raise_valid, complete;
`ifdef ALU_DRV_TAG_EN
  logic [3:0]       push_tag;
  logic [3:0]       alu_tag;
`endif

  assign push           = bus.cmd_valid && bus.cmd_ready;
  assign pop            = (state == S_IDLE) && (occ != '0);
  assign bus.issued_cnt = issued_q;

  always_comb begin
    wr_entry    = '0;
    wr_entry.a  = bus.cmd_a;
    wr_entry.b  = bus.cmd_b;
    wr_entry.op = bus.cmd_op;
`ifdef ALU_DRV_TAG_EN
    wr_entry.tag = push_tag;
`endif
  end

  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + OCC_W'(1);
    else if (!push && pop) occ_next = occ - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Response is captured in CAPT and raised on the following edge, so the data is
  // already settled in rsp_* for the whole time rsp_valid is high.
  always_comb begin
    state_next  = state;
    load_alu    = 1'b0;
    capture     = 1'b0;
    raise_valid = 1'b0;
    complete    = 1'b0;
    unique case (state)
      S_IDLE:  if (pop) state_next = S_ISSUE;
      S_ISSUE: begin
        load_alu   = 1'b1;
        state_next = (ALU_LAT > 1) ? S_WAIT : S_CAPT;
      end
      S_WAIT:  if (lat_cnt == LAT_W'(LAT_LAST)) state_next = S_CAPT;
      S_CAPT: begin
        capture    = 1'b1;
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.rsp_valid) begin
          raise_valid = 1'b1;
        end else if (bus.rsp_ready) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers, occupancy and the registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      cur           <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
`ifdef ALU_DRV_TAG_EN
      push_tag      <= '0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
`ifdef ALU_DRV_TAG_EN
        push_tag <= push_tag + 4'(1);
`endif
      end
      if (pop) begin
        cur    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ           <= occ_next;
      bus.cmd_ready <= (occ_next != OCC_W'(DEPTH));
      bus.busy      <= (state_next != S_IDLE) || (occ_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) lat_cnt <= '0;
    else                        lat_cnt <= lat_cnt + LAT_W'(1);
  end

  // ALU operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_a     <= '0;
      bus.rsp_b     <= '0;
      bus.rsp_op    <= '0;
      bus.rsp_out   <= '0;
      issued_q      <= '0;
`ifdef ALU_DRV_TAG_EN
      alu_tag       <= '0;
      bus.rsp_tag   <= '0;
`endif
    end else begin
      if (load_alu) begin
        bus.alu_a  <= cur.a;
        bus.alu_b  <= cur.b;
        bus.alu_op <= cur.op;
`ifdef ALU_DRV_TAG_EN
        alu_tag    <= cur.tag;
`endif
      end
      if (capture) begin
        bus.rsp_out <= bus.alu_out;
        bus.rsp_a   <= bus.alu_a;
        bus.rsp_b   <= bus.alu_b;
        bus.rsp_op  <= bus.alu_op;
`ifdef ALU_DRV_TAG_EN
        bus.rsp_tag <= alu_tag;
`endif
      end
      if (raise_valid) bus.rsp_valid <= 1'b1;
      if (complete) begin
        bus.rsp_valid <= 1'b0;
        issued_q      <= issued_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: ALU_LAT=1/CNT_W=4 instance and ALU_LAT=3 instance,
// each driving an adder stub out = a + b (9-bit).
module tb_alu_cmd_driver;
  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  bit   ok;

  always #5 clk = ~clk;

  alu_cmd_driver_if #(.CNT_W(4))  if0 ();
  alu_cmd_driver_if #(.CNT_W(16)) if1 ();

  assign if0.alu_out = {1'b0, if0.alu_a} + {1'b0, if0.alu_b};
  assign if1.alu_out = {1'b0, if1.alu_a} + {1'b0, if1.alu_b};

  alu_cmd_driver #(.DEPTH(4), .ALU_LAT(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(if0)
  );
  alu_cmd_driver #(.DEPTH(4), .ALU_LAT(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(if1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if0.cmd_a = a; if0.cmd_b = b; if0.cmd_op = op; if0.cmd_valid = 1'b1;
    tick(1);
    if0.cmd_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if1.cmd_a = a; if1.cmd_b = b; if1.cmd_op = op; if1.cmd_valid = 1'b1;
    tick(1);
    if1.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp0(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if0.rsp_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    if0.cmd_valid = 1'b0; if0.cmd_a = '0; if0.cmd_b = '0; if0.cmd_op = '0; if0.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_a = '0; if1.cmd_b = '0; if1.cmd_op = '0; if1.rsp_ready = 1'b0;
    tick(2);
    rst0 = 1'b0; rst1 = 1'b0;

    // reset state
    chk("rst_cmd_ready", 32'(if0.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("rst_busy",      32'(if0.busy),      32'd0);
    chk("rst_issued",    32'(if0.issued_cnt), 32'd0);
    chk("rst_alu_a",     32'(if0.alu_a),     32'd0);
    chk("rst_rsp_out",   32'(if0.rsp_out),   32'd0);
    chk("rst1_cmd_ready", 32'(if1.cmd_ready), 32'd1);

    // 1: 5+5, response at push+4 edges
    if0.rsp_ready = 1'b1;
    push0(8'd5, 8'd5, 4'd0);
    tick(3);
    chk("t1_not_yet", 32'(if0.rsp_valid), 32'd0);
    tick(1);
    chk("t1_valid",   32'(if0.rsp_valid), 32'd1);
    chk("t1_out",     32'(if0.rsp_out),   32'd10);
    chk("t1_op",      32'(if0.rsp_op),    32'd0);
    chk("t1_a",       32'(if0.rsp_a),     32'd5);
    chk("t1_b",       32'(if0.rsp_b),     32'd5);
    tick(1);
    chk("t1_issued",  32'(if0.issued_cnt), 32'd1);
    chk("t1_dropped", 32'(if0.rsp_valid), 32'd0);

    // 2: carry into bit 8, operands held after completion
    push0(8'hFF, 8'h01, 4'd3);
    wait_rsp0(ok);
    chk("t2_timeout", 32'(ok), 32'd1);
    chk("t2_out",     32'(if0.rsp_out), 32'h100);
    chk("t2_op",      32'(if0.rsp_op),  32'd3);
    tick(4);
    chk("t2_alu_a_held", 32'(if0.alu_a),  32'hFF);
    chk("t2_alu_op_held", 32'(if0.alu_op), 32'd3);
    chk("t2_issued",  32'(if0.issued_cnt), 32'd2);
    chk("t2_idle",    32'(if0.busy),       32'd0);

    // 3: backpressure; FSM parked in HOLD, FIFO fills to 4, 5th refused
    if0.rsp_ready = 1'b0;
    push0(8'd1, 8'd2, 4'd4);
    wait_rsp0(ok);
    chk("t3_first_timeout", 32'(ok), 32'd1);
    chk("t3_first_out", 32'(if0.rsp_out), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_before_push", 32'(if0.cmd_ready), 32'd1);
      push0(8'(10 + i), 8'(i), 4'(i));
    end
    chk("t3_full", 32'(if0.cmd_ready), 32'd0);
    push0(8'd99, 8'd99, 4'd9);
    tick(4);
    chk("t3_still_full", 32'(if0.cmd_ready), 32'd0);
    chk("t3_hold_valid", 32'(if0.rsp_valid), 32'd1);
    chk("t3_hold_a",     32'(if0.rsp_a),     32'd1);
    chk("t3_hold_out",   32'(if0.rsp_out),   32'd3);
    chk("t3_hold_op",    32'(if0.rsp_op),    32'd4);
    if0.rsp_ready = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      wait_rsp0(ok);
      chk("t3_order_timeout", 32'(ok), 32'd1);
      chk("t3_order_a",   32'(if0.rsp_a),   32'(10 + i));
      chk("t3_order_out", 32'(if0.rsp_out), 32'(10 + 2 * i));
      tick(1);
    end
    tick(20);
    chk("t3_no_fifth", 32'(if0.rsp_valid),  32'd0);
    chk("t3_drained",  32'(if0.busy),       32'd0);
    chk("t3_issued",   32'(if0.issued_cnt), 32'd7);

    // 5: 17 commands through a 4-bit counter
    rst0 = 1'b1;
    tick(1);
    rst0 = 1'b0;
    chk("t5_rst_issued", 32'(if0.issued_cnt), 32'd0);
    for (int i = 0; i < 17; i++) begin
      push0(8'(i), 8'(2 * i), 4'(i));
      wait_rsp0(ok);
      chk("t5_timeout", 32'(ok), 32'd1);
      chk("t5_out", 32'(if0.rsp_out), 32'(3 * i));
`ifdef ALU_DRV_TAG_EN
      chk("t5_tag", 32'(if0.rsp_tag), 32'(i % 16));
`endif
      tick(1);
      if (i == 15) chk("t5_wrap_zero", 32'(if0.issued_cnt), 32'd0);
    end
    chk("t5_wrap_one", 32'(if0.issued_cnt), 32'd1);

    // 4: reset during WAIT (ALU_LAT=3) discards the command
    if1.rsp_ready = 1'b1;
    push1(8'd7, 8'd8, 4'd2);
    tick(2);
    chk("t4_busy_in_wait", 32'(if1.busy),  32'd1);
    chk("t4_alu_a_driven", 32'(if1.alu_a), 32'd7);
    rst1 = 1'b1;
    tick(1);
    rst1 = 1'b0;
    chk("t4_rsp_valid", 32'(if1.rsp_valid),  32'd0);
    chk("t4_busy",      32'(if1.busy),       32'd0);
    chk("t4_cmd_ready", 32'(if1.cmd_ready),  32'd1);
    chk("t4_issued",    32'(if1.issued_cnt), 32'd0);
    chk("t4_alu_a",     32'(if1.alu_a),      32'd0);
    tick(15);
    chk("t4_never_valid", 32'(if1.rsp_valid),  32'd0);
    chk("t4_never_count", 32'(if1.issued_cnt), 32'd0);

    // ALU_LAT=3 latency: valid at push+6 edges
    push1(8'd3, 8'd4, 4'd1);
    tick(5);
    chk("t4_lat_not_yet", 32'(if1.rsp_valid), 32'd0);
    tick(1);
    chk("t4_lat_valid",   32'(if1.rsp_valid), 32'd1);
    chk("t4_lat_out",     32'(if1.rsp_out),   32'd7);
    tick(1);
    chk("t4_lat_issued",  32'(if1.issued_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
